// File: rtl/mem_io_bridge.sv
// Memory-port address decoder with a small board I/O register file.
// Sits between the multicycle controller/datapath and block RAM. I/O reads
// are registered so they share the RAM's one-cycle read latency.
module mem_io_bridge #(
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter int          TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  output logic [15:0] rd_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic [9:0]  sw_in,
  input  logic [3:0]  btn_in,
  output logic [9:0]  led_out,
  output logic [15:0] hex_out
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_TC = PW'(TICK_DIV - 1);

  logic          io_hit;
  logic [15:0]   off;
  logic          wr_io;
  logic          we_btn, we_led, we_hex, we_timer, we_tctrl;
  logic          tick;
  logic          wrap_set;
  logic [3:0]    btn_rise;
  logic [15:0]   rd_mux;

  logic [9:0]    sw_s1, sw_s2;
  logic [3:0]    btn_s1, btn_s2, btn_prev;
  logic [3:0]    btn_evt;
  logic [9:0]    led_q;
  logic [15:0]   hex_q;
  logic [15:0]   timer_q;
  logic [PW-1:0] presc_q;
  logic          en_q;
  logic          wrap_q;
  logic          io_sel_q;
  logic [15:0]   io_q;

  assign io_hit    = (addr >= IO_BASE);
  assign off       = addr - IO_BASE;
  assign ram_addr  = addr;
  assign ram_wdata = wr_data;
  assign ram_we    = wr_en & ~io_hit;

  assign wr_io    = wr_en & io_hit;
  assign we_btn   = wr_io & (off == 16'd1);
  assign we_led   = wr_io & (off == 16'd2);
  assign we_hex   = wr_io & (off == 16'd3);
  assign we_timer = wr_io & (off == 16'd4);
  assign we_tctrl = wr_io & (off == 16'd5);

  assign tick     = en_q & (presc_q == PRESC_TC);
  // A TIMER write on a tick edge replaces the increment, so it cannot wrap.
  assign wrap_set = tick & ~we_timer & (timer_q == 16'hFFFF);
  assign btn_rise = btn_s2 & ~btn_prev;

  assign led_out = led_q;
  assign hex_out = hex_q;
  assign rd_data = io_sel_q ? io_q : ram_rdata;

  // Register-file read mux on current (pre-write) values
  always_comb begin
    rd_mux = 16'h0000;
    case (off)
      16'd0:   rd_mux = {6'b0, sw_s2};
      16'd1:   rd_mux = {12'b0, btn_evt};
      16'd2:   rd_mux = {6'b0, led_q};
      16'd3:   rd_mux = hex_q;
      16'd4:   rd_mux = timer_q;
      16'd5:   rd_mux = {14'b0, wrap_q, en_q};
      default: rd_mux = 16'h0000;
    endcase
  end

  // Synchronize switches and buttons; third button flop feeds edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      sw_s1    <= sw_in;
      sw_s2    <= sw_s1;
      btn_s1   <= btn_in;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  // Sticky button events; a new edge wins over a same-edge W1C
  always_ff @(posedge clk) begin
    if (reset) btn_evt <= '0;
    else       btn_evt <= (btn_evt & ~(we_btn ? wr_data[3:0] : 4'b0)) | btn_rise;
  end

  // LED and hex display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      hex_q <= '0;
    end else begin
      if (we_led) led_q <= wr_data[9:0];
      if (we_hex) hex_q <= wr_data;
    end
  end

  // Millisecond timer: prescaler plus 16-bit count, frozen while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      presc_q <= '0;
    end else if (we_timer) begin
      timer_q <= wr_data;
      presc_q <= '0;
    end else if (en_q) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) timer_q <= timer_q + 16'd1;
    end
  end

  // Timer control: EN is plain RW, WRAP is sticky with W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (we_tctrl) en_q <= wr_data[0];
      wrap_q <= (wrap_q & ~(we_tctrl & wr_data[1])) | wrap_set;
    end
  end

  // Registered read path matching the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      io_sel_q <= 1'b0;
      io_q     <= '0;
    end else begin
      io_sel_q <= io_hit;
      io_q     <= rd_mux;
    end
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Address decoder and memory-mapped I/O block sitting directly downstream of the multicycle controller and datapath on the memory port. It routes every fetch, load and store either to the block RAM or to a small register file of board I/O: switches, button events, LEDs, hex display and a millisecond timer. It returns read data with the same one-cycle latency as the synchronous-read RAM, so the controller's FETCH / LB_MEM / LB_LOAD sequencing is unchanged.

## Interface
- `IO_BASE`, default 16'hFF00: first I/O address; addresses >= IO_BASE are I/O.
- `TICK_DIV`, default 50000: clk cycles per timer tick (1 ms at 50 MHz); must be >= 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  16  word address from the datapath memory-address mux.
- `wr_data`  in  16  store data from the datapath memory-data mux.
- `wr_en`  in  1  store strobe (controller MEM_WR_S).
- `rd_data`  out  16  read data, valid the cycle after `addr` is presented.
- `ram_addr`  out  16  RAM address, equal to `addr` (combinational).
- `ram_wdata`  out  16  equal to `wr_data`.
- `ram_we`  out  1  `wr_en & ~io_hit`.
- `ram_rdata`  in  16  RAM synchronous read data (1-cycle latency).
- `sw_in`  in  10  raw slide switches (asynchronous).
- `btn_in`  in  4  raw push buttons, active-high (asynchronous).
- `led_out`  out  10  LED register.
- `hex_out`  out  16  four-nibble hex display register.

## Operation
- `io_hit = (addr >= IO_BASE)`. Register offset `off = addr - IO_BASE`.
- Register map, reads zero-extended to 16 bits:
  - off 0 SW: RO; two-flop synchronized `sw_in`.
  - off 1 BTN_EVT: bits[3:0] sticky rising-edge events of synchronized `btn_in`; W1C.
  - off 2 LED: RW, bits[9:0].
  - off 3 HEX: RW, 16 bits.
  - off 4 TIMER: R current count; W loads count and clears prescaler.
  - off 5 TCTRL: bit0 EN (RW), bit1 WRAP sticky (W1C); other bits read 0.
  - off >= 6: read 0, writes ignored, never reach RAM.
- Button path: two-flop synchronizer, then a third flop for edge detect; event bit sets when synced=1 and prev=0.
- Timer: prescaler counts 0..TICK_DIV-1 while EN=1 and emits a tick on its terminal count; each tick increments TIMER modulo 2^16; 16'hFFFF -> 0 sets WRAP. EN=0 freezes prescaler and TIMER (values held).
- Read path: on each edge, register `io_sel_q <= io_hit` and `io_q <= mux(off)`; `rd_data = io_sel_q ? io_q : ram_rdata`.
- Priorities on the same edge:
  - TIMER write beats tick increment; the written value is kept, no WRAP set.
  - Event/WRAP set beats W1C clear of the same bit.
  - Reading a register in the cycle it is written returns the old value.
- RAM stores with `addr` in I/O space are suppressed (`ram_we=0`).

## Timing
- Reset (synchronous, active-high) values: led_out=0, hex_out=0, TIMER=0, prescaler=0, EN=0, WRAP=0, BTN_EVT=0, all sync/edge flops 0, io_sel_q=0, io_q=0; thus rd_data = ram_rdata after reset.
- Reset asserted mid-operation clears all of the above on that edge; a concurrent `wr_en` is ignored.
- Read latency: exactly 1 cycle for both RAM and I/O.
- Write: takes effect on the edge where `wr_en=1`; visible on `led_out`/`hex_out` the following cycle.
- Switch/button latency: a change is visible in SW and sets BTN_EVT 2 cycles after the input changes (BTN_EVT sets on the third edge).
- Timer: with EN set at edge 0, the first TIMER increment occurs TICK_DIV edges later.

## Test plan
- Reset then read addr 16'h0010 with ram_rdata=16'hBEEF -> rd_data=16'hBEEF next cycle; led_out=0, hex_out=0.
- Write 16'h03A5 to FF02 and 16'h1234 to FF03 -> led_out=10'h3A5, hex_out=16'h1234, ram_we stays 0; readback returns 16'h03A5 / 16'h1234.
- Pulse btn_in[2] high for 5 cycles -> BTN_EVT reads 16'h0004; write 16'h0004 to FF01 -> reads 0; an edge coincident with the clear leaves the bit set.
- TICK_DIV=4: write FFFE to FF04, write 1 to FF05 -> TIMER=FFFF after 4 cycles, 0 after 8 with TCTRL reading 16'h0003; a TIMER write on a tick edge wins.
- Store to FF07 -> ram_we=0, no register changes, read of FF07 returns 0; store to 16'h0100 -> ram_we=1.
- Assert reset while EN=1 and LED=16'h00FF -> all outputs and registers return to reset values on the next edge.
